// File: rtl/window_3x3_gen_pkg.sv
// Shared defaults and FSM state encodings for the 3x3 window generator.
package window_3x3_gen_pkg;

    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;
    localparam int DEF_PIX_W = 13;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bus of the 3x3 window generator.
interface window_3x3_gen_if
    import window_3x3_gen_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic [PIX_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic [XW-1:0]    out_x;
    logic [YW-1:0]    out_y;
    logic             frame_done;

    modport slave (
        input  in_valid, in_pixel,
        output in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
               out_x, out_y, frame_done
    );

    modport master (
        output in_valid, in_pixel,
        input  in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
               out_x, out_y, frame_done
    );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// One-row pixel delay: a shift register of DEPTH entries advancing one slot per enable.
module window_3x3_gen_line_buffer #(
    parameter int DEPTH = 64,
    parameter int PIX_W = 13
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] dout_o
);
    // Contents are never reset; stale data is masked by the window padding.
    logic [DEPTH-1:0][PIX_W-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (en_i) mem_q <= {mem_q[DEPTH-2:0], din_i};
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming raster-order 3x3 neighbourhood generator with zero padding at the image borders.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    window_3x3_gen_if.slave bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [1:0]                 state_q, state_d;
    logic [XW-1:0]              in_x_q, in_x_d, cx_q, cx_d, out_x_q;
    logic [YW-1:0]              in_y_q, in_y_d, cy_q, cy_d, out_y_q;
    logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
    logic [8:0][PIX_W-1:0]      pix_q, pix_d;
    logic                       out_valid_q, frame_done_q;
    logic                       drain, accept, step, emit, c_last;
    logic [PIX_W-1:0]           pix_in;
    logic [PIX_W-1:0]           lb_chain [3];

    always_comb begin
        drain  = (state_q == ST_DRAIN);
        accept = bus.in_valid && !drain;
        // Drain keeps the pipeline moving with zero pixels until the last centre is out.
        step   = accept || drain;
        pix_in = drain ? '0 : bus.in_pixel;
        emit   = step && ((state_q == ST_RUN) || drain);
        c_last = (cx_q == X_LAST) && (cy_q == Y_LAST);

        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb_chain[2];
        win_d[1][2] = lb_chain[1];
        win_d[2][2] = pix_in;

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pix_d[r*3+c] = ((r == 0 && cy_q == '0) || (r == 2 && cy_q == Y_LAST) ||
                                (c == 0 && cx_q == '0) || (c == 2 && cx_q == X_LAST))
                               ? '0 : win_d[r][c];
            end
        end

        in_x_d = in_x_q;
        in_y_d = in_y_q;
        if (accept) begin
            if (in_x_q == X_LAST) begin
                in_x_d = '0;
                in_y_d = (in_y_q == Y_LAST) ? '0 : in_y_q + 1'b1;
            end else begin
                in_x_d = in_x_q + 1'b1;
            end
        end

        cx_d = cx_q;
        cy_d = cy_q;
        if (emit) begin
            if (cx_q == X_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_FILL;
            // Pixel (0,1) is the IMG_W+1-th accept; the next accept completes window (0,0).
            ST_FILL:  if (accept && in_x_q == '0 && in_y_q == YW'(1)) state_d = ST_RUN;
            ST_RUN:   if (accept && in_x_q == X_LAST && in_y_q == Y_LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (c_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign lb_chain[0] = pix_in;

    for (genvar i = 0; i < 2; i++) begin : g_lb
        window_3x3_gen_line_buffer #(
            .DEPTH (IMG_W),
            .PIX_W (PIX_W)
        ) u_lb (
            .clk    (clk),
            .en_i   (step),
            .din_i  (lb_chain[i]),
            .dout_o (lb_chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (step) win_q <= win_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_x_q       <= '0;
            in_y_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            pix_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_x_q       <= in_x_d;
            in_y_q       <= in_y_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            out_valid_q  <= emit;
            frame_done_q <= emit && c_last;
            if (emit) begin
                pix_q   <= pix_d;
                out_x_q <= cx_q;
                out_y_q <= cy_q;
            end
        end
    end

    assign bus.in_ready   = !drain;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.p0 = pix_q[0];
    assign bus.p1 = pix_q[1];
    assign bus.p2 = pix_q[2];
    assign bus.p3 = pix_q[3];
    assign bus.p4 = pix_q[4];
    assign bus.p5 = pix_q[5];
    assign bus.p6 = pix_q[6];
    assign bus.p7 = pix_q[7];
    assign bus.p8 = pix_q[8];

endmodule
